// File: rtl/fip_3x3_det_seq.sv
// Sequential fixed-point 3x3 determinant engine: one shared signed multiplier, cofactor expansion
// along row 0, with per-stage overflow tracking and optional saturation.
//
// state | meaning
// IDLE  | ready for a matrix; registers i_array on i_valid
// MINOR | six 2x2 minor products ei, fh, fg, di, dh, eg (cnt 0..5)
// DIFF  | forms the three minor differences in one edge
// COF   | a, b, c times their minors, summed into acc (cnt 0..2)
// DONE  | result presented until the downstream accepts it
module fip_3x3_det_seq #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int SATURATE = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [2:0][2:0][WIDTH-1:0]   i_array,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [WIDTH-1:0]             o_det,
  output logic                         o_overflow,
  output logic                         o_ovf_sticky,
  input  logic                         i_clr_sticky
);

  // Every stage result is sign-extended to EW before the range check.
  localparam int EW = 2*WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MINOR = 3'd1,
    DIFF  = 3'd2,
    COF   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [2:0][2:0][WIDTH-1:0] m;
  logic [5:0][WIDTH-1:0]      p;
  logic [WIDTH-1:0]           inter1, inter2, inter3;
  logic [WIDTH+1:0]           acc;
  logic [2:0]                 cnt;
  logic                       job_ovf;

  function automatic logic fits(input logic [EW-1:0] v);
    return (&v[EW-1:WIDTH-1]) || !(|v[EW-1:WIDTH-1]);
  endfunction

  function automatic logic [WIDTH-1:0] clip(input logic [EW-1:0] v);
    if (fits(v) || SATURATE == 0)
      return v[WIDTH-1:0];
    else if (v[EW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  logic [WIDTH-1:0] el_a, el_b, el_c, el_d, el_e, el_f, el_g, el_h, el_i;
  assign el_a = m[0][0];
  assign el_b = m[0][1];
  assign el_c = m[0][2];
  assign el_d = m[1][0];
  assign el_e = m[1][1];
  assign el_f = m[1][2];
  assign el_g = m[2][0];
  assign el_h = m[2][1];
  assign el_i = m[2][2];

  // Shared multiplier and its operand selection
  logic [WIDTH-1:0]          mul_a, mul_b;
  logic signed [2*WIDTH-1:0] mul_ax, mul_bx, mul_full, mul_shr;
  logic [EW-1:0]             mul_ext;
  logic [WIDTH-1:0]          mul_res;
  logic                      mul_ovf;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MINOR: begin
        case (cnt)
          3'd0:    begin mul_a = el_e; mul_b = el_i; end
          3'd1:    begin mul_a = el_f; mul_b = el_h; end
          3'd2:    begin mul_a = el_f; mul_b = el_g; end
          3'd3:    begin mul_a = el_d; mul_b = el_i; end
          3'd4:    begin mul_a = el_d; mul_b = el_h; end
          default: begin mul_a = el_e; mul_b = el_g; end
        endcase
      end
      COF: begin
        case (cnt)
          3'd0:    begin mul_a = el_a; mul_b = inter1; end
          3'd1:    begin mul_a = el_b; mul_b = inter2; end
          default: begin mul_a = el_c; mul_b = inter3; end
        endcase
      end
      default: ;
    endcase
  end

  assign mul_ax   = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
  assign mul_bx   = {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
  assign mul_full = mul_ax * mul_bx;
  assign mul_shr  = mul_full >>> FRAC;
  assign mul_ext  = {{2{mul_shr[2*WIDTH-1]}}, mul_shr};
  assign mul_ovf  = !fits(mul_ext);
  assign mul_res  = clip(mul_ext);

  // p holds the minors oldest-first: p[5]=ei, p[4]=fh, p[3]=fg, p[2]=di, p[1]=dh, p[0]=eg
  logic [WIDTH:0]   sub1, sub2, sub3;
  logic [EW-1:0]    sub1_ext, sub2_ext, sub3_ext;
  assign sub1     = {p[5][WIDTH-1], p[5]} - {p[4][WIDTH-1], p[4]};
  assign sub2     = {p[3][WIDTH-1], p[3]} - {p[2][WIDTH-1], p[2]};
  assign sub3     = {p[1][WIDTH-1], p[1]} - {p[0][WIDTH-1], p[0]};
  assign sub1_ext = {{(EW-WIDTH-1){sub1[WIDTH]}}, sub1};
  assign sub2_ext = {{(EW-WIDTH-1){sub2[WIDTH]}}, sub2};
  assign sub3_ext = {{(EW-WIDTH-1){sub3[WIDTH]}}, sub3};

  logic [WIDTH+1:0] acc_nxt;
  logic [EW-1:0]    acc_ext;
  assign acc_nxt = acc + {{2{mul_res[WIDTH-1]}}, mul_res};
  assign acc_ext = {{(EW-WIDTH-2){acc_nxt[WIDTH+1]}}, acc_nxt};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)      state_nxt = MINOR;
      MINOR:   if (cnt == 3'd5)  state_nxt = DIFF;
      DIFF:                      state_nxt = COF;
      COF:     if (cnt == 3'd2)  state_nxt = DONE;
      DONE:    if (i_ready)      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m          <= '0;
      p          <= '0;
      inter1     <= '0;
      inter2     <= '0;
      inter3     <= '0;
      acc        <= '0;
      cnt        <= '0;
      job_ovf    <= 1'b0;
      o_det      <= '0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            m       <= i_array;
            cnt     <= '0;
            job_ovf <= 1'b0;
          end
        end
        MINOR: begin
          p       <= {p[4:0], mul_res};
          job_ovf <= job_ovf | mul_ovf;
          cnt     <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
        end
        DIFF: begin
          inter1  <= clip(sub1_ext);
          inter2  <= clip(sub2_ext);
          inter3  <= clip(sub3_ext);
          job_ovf <= job_ovf | !fits(sub1_ext) | !fits(sub2_ext) | !fits(sub3_ext);
          acc     <= '0;
          cnt     <= '0;
        end
        COF: begin
          acc     <= acc_nxt;
          job_ovf <= job_ovf | mul_ovf;
          cnt     <= cnt + 3'd1;
          if (cnt == 3'd2) begin
            o_det      <= clip(acc_ext);
            o_overflow <= job_ovf | mul_ovf | !fits(acc_ext);
          end
        end
        default: ;
      endcase
    end
  end

  // Clear takes priority over a same-edge handshake set
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      o_ovf_sticky <= 1'b0;
    else if (i_clr_sticky)
      o_ovf_sticky <= 1'b0;
    else if (state == DONE && i_ready)
      o_ovf_sticky <= o_ovf_sticky | o_overflow;
  end

endmodule

// File: tb/tb_fip_3x3_det_seq.sv
// Scoreboard bench for fip_3x3_det_seq: a wrapping and a saturating instance share all inputs
// and are checked against a plain-arithmetic determinant model.
module tb_fip_3x3_det_seq;
  localparam int W   = 32;
  localparam int ONE = 65536;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0, rstn = 1'b0, i_valid = 1'b0, i_ready = 1'b0, clr = 1'b0;
  logic [2:0][2:0][W-1:0] arr = '0;
  logic rdy0, v0, ov0, st0, rdy1, v1, ov1, st1;
  logic [W-1:0] det0, det1;

  fip_3x3_det_seq #(.WIDTH(W), .FRAC(16), .SATURATE(0)) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(rdy0), .i_array(arr),
    .o_valid(v0), .i_ready(i_ready), .o_det(det0), .o_overflow(ov0),
    .o_ovf_sticky(st0), .i_clr_sticky(clr));

  fip_3x3_det_seq #(.WIDTH(W), .FRAC(16), .SATURATE(1)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(rdy1), .i_array(arr),
    .o_valid(v1), .i_ready(i_ready), .o_det(det1), .o_overflow(ov1),
    .o_ovf_sticky(st1), .i_clr_sticky(clr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: Q16.16 arithmetic on 64-bit integers
  function automatic longint red(input longint v, input bit sat, inout bit ovf);
    if (v > MAXV || v < MINV) begin
      ovf = 1'b1;
      if (sat) return (v > 0) ? MAXV : MINV;
      return longint'(int'(v));
    end
    return v;
  endfunction

  function automatic longint mulq(input longint x, input longint y, input bit sat, inout bit ovf);
    return red((x * y) >>> 16, sat, ovf);
  endfunction

  function automatic void model(input logic [2:0][2:0][31:0] m, input bit sat,
                                output logic [31:0] det, output bit ovf);
    longint x[9];
    longint ei, fh, fg, di, dh, eg, t1, t2, t3, acc, d;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        x[r*3+c] = longint'(int'(m[r][c]));
    ovf = 1'b0;
    ei = mulq(x[4], x[8], sat, ovf);
    fh = mulq(x[5], x[7], sat, ovf);
    fg = mulq(x[5], x[6], sat, ovf);
    di = mulq(x[3], x[8], sat, ovf);
    dh = mulq(x[3], x[7], sat, ovf);
    eg = mulq(x[4], x[6], sat, ovf);
    t1 = red(ei - fh, sat, ovf);
    t2 = red(fg - di, sat, ovf);
    t3 = red(dh - eg, sat, ovf);
    acc = mulq(x[0], t1, sat, ovf) + mulq(x[1], t2, sat, ovf) + mulq(x[2], t3, sat, ovf);
    d = red(acc, sat, ovf);
    det = d[31:0];
  endfunction

  typedef struct {
    logic [31:0] d0;
    bit          o0;
    logic [31:0] d1;
    bit          o1;
    int          ac;
  } exp_t;

  exp_t q[$];
  bit sm0 = 1'b0, sm1 = 1'b0, prev_v = 1'b0;

  // Acceptance capture and output monitor, both sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      prev_v = 1'b0;
    end else begin
      if (i_valid && rdy0) begin
        model(arr, 1'b0, e.d0, e.o0);
        model(arr, 1'b1, e.d1, e.o1);
        e.ac = cyc + 1;
        q.push_back(e);
      end
      chk("sticky0", st0, sm0);
      chk("sticky1", st1, sm1);
      if (v0 && !prev_v) begin
        if (q.size() == 0) chk("unexpected_valid", v0, 0);
        else chk("latency", cyc - q[0].ac, 10);
      end
      if (v0 && i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_handshake", v0, 0);
        end else begin
          e = q.pop_front();
          chk("det_wrap", det0, e.d0);
          chk("ovf_wrap", ov0, e.o0);
          chk("valid_sat", v1, 1);
          chk("det_sat", det1, e.d1);
          chk("ovf_sat", ov1, e.o1);
          sm0 = sm0 | e.o0;
          sm1 = sm1 | e.o1;
        end
      end
      if (clr) begin
        sm0 = 1'b0;
        sm1 = 1'b0;
      end
      prev_v = v0;
    end
  end

  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      i_ready = ($urandom % 4) != 0;
      clr     = ($urandom % 24) == 0;
    end
  end

  function automatic logic [2:0][2:0][31:0] mat(input int a, b, c, d, e, f, g, h, k);
    logic [2:0][2:0][31:0] m;
    m[0][0] = a; m[0][1] = b; m[0][2] = c;
    m[1][0] = d; m[1][1] = e; m[1][2] = f;
    m[2][0] = g; m[2][1] = h; m[2][2] = k;
    return m;
  endfunction

  function automatic int rnd_elem();
    case ($urandom % 3)
      0:       return int'($urandom_range(0, 524288)) - 262144;
      1:       return int'($urandom);
      default: return (int'($urandom_range(0, 20)) - 10) * ONE;
    endcase
  endfunction

  // All driving tasks start and end at posedge+1
  task automatic send(input logic [2:0][2:0][31:0] m);
    for (int k = 0; k < 100 && !rdy0; k++) begin @(posedge clk); #1; end
    chk("send_ready", rdy0, 1);
    i_valid = 1'b1;
    arr = m;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 60 && !v0; k++) begin @(posedge clk); #1; end
    chk("valid_timeout", v0, 1);
  endtask

  task automatic job(input logic [2:0][2:0][31:0] m, input logic [31:0] ed0, input bit eo0,
                     input logic [31:0] ed1);
    send(m);
    wait_valid();
    chk("dir_det_wrap", det0, ed0);
    chk("dir_ovf_wrap", ov0, eo0);
    chk("dir_det_sat", det1, ed1);
    @(posedge clk); #1;
    chk("ready_after_hs", rdy0, 1);
    chk("valid_after_hs", v0, 0);
  endtask

  logic [2:0][2:0][31:0] ident, diag100;
  logic [31:0] hold;

  initial begin
    ident   = mat(ONE, 0, 0, 0, ONE, 0, 0, 0, ONE);
    diag100 = mat(100*ONE, 0, 0, 0, 100*ONE, 0, 0, 0, 100*ONE);

    #2;
    chk("rst_valid", v0, 0);
    chk("rst_det", det0, 0);
    chk("rst_ovf", ov0, 0);
    chk("rst_sticky", st0, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", rdy0, 1);

    i_ready = 1'b1;
    job(ident, 32'h0001_0000, 0, 32'h0001_0000);
    job(mat(2*ONE, 0, 0, 0, 3*ONE, 0, 0, 0, 4*ONE), 32'h0018_0000, 0, 32'h0018_0000);
    job(mat(ONE, 2*ONE, 3*ONE, 4*ONE, 5*ONE, 6*ONE, 7*ONE, 8*ONE, 9*ONE), 32'h0, 0, 32'h0);
    job(diag100, 32'h4240_0000, 1, 32'h7FFF_FFFF);
    chk("sticky_after_ovf", st0, 1);
    chk("sticky_sat_after_ovf", st1, 1);

    // Backpressure: a pending i_valid must wait for the return to IDLE
    i_ready = 1'b0;
    send(mat(-3*ONE, ONE/2, 7, 11, 2*ONE, -5, ONE, 3, -ONE));
    wait_valid();
    hold = det0;
    i_valid = 1'b1;
    arr = mat(2*ONE, 0, 0, 0, 3*ONE, 0, 0, 0, 4*ONE);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", v0, 1);
      chk("bp_ready", rdy0, 0);
      chk("bp_det", det0, hold);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_idle", rdy0, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("bp_accepted", rdy0, 0);
    wait_valid();
    chk("bp_next_det", det0, 32'h0018_0000);
    @(posedge clk); #1;

    // Clear wins over a same-edge overflow handshake
    i_ready = 1'b0;
    send(diag100);
    wait_valid();
    i_ready = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_wins0", st0, 0);
    chk("clr_wins1", st1, 0);

    // Reset four edges into a job
    job(diag100, 32'h4240_0000, 1, 32'h7FFF_FFFF);
    send(ident);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_valid", v0, 0);
    chk("midrst_det", det0, 0);
    chk("midrst_sticky", st0, 0);
    chk("midrst_det_sat", det1, 0);
    q.delete();
    sm0 = 1'b0;
    sm1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("no_stale_valid", v0, 0);
    job(ident, 32'h0001_0000, 0, 32'h0001_0000);

    // Randomised phase
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send(mat(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem(),
               rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem()));
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) begin @(posedge clk); #1; end
    chk("drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
